baseline_multiscale: RTL and testbench

//  Parametrised multi-timescale baseline estimator for one feature stream (e.g. line length).
//  - Bins valid input samples into fixed-length bins, then cascades three sliding-window running-sum levels.
//  - Each level decimates into the next; defaults give 1 s bins, then 5 s, 30 s and 240 s windows.
//  - Output is the arithmetic-right-shifted 240 s sum.
//  - Sits after the per-channel feature extractor and feeds the seizure-detect threshold compare.

---
 rtl/baseline_multiscale_pkg.sv | 19 +
 rtl/baseline_multiscale_window.sv | 70 +++++++
 rtl/baseline_multiscale.sv | 163 ++++++++++++++++
 tb/tb_baseline_multiscale.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/baseline_multiscale_pkg.sv
// Shared width helpers and default timing constants for the
// multi-timescale baseline estimator.
package baseline_pkg;

    localparam int SAMP_PER_BIN_DEF = 250;
    localparam int D1_DEF           = 5;
    localparam int D2_DEF           = 6;
    localparam int D3_DEF           = 8;

    // Extra bits needed to hold a sum of n terms; 0 for n <= 1.
    function automatic int clog2w(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/baseline_multiscale_window.sv
// One sliding-window running-sum level: ring buffer, running sum,
// saturating fill count and optional decimating emit counter.
module window_level
    import baseline_pkg::*;
#(
    parameter  int IN_W       = 27,
    parameter  int DEPTH      = 5,
    parameter  int EMIT_EVERY = 5,
    parameter  bit EMIT_EN    = 1'b1,
    localparam int OUT_W      = IN_W + clog2w(DEPTH),
    localparam int FW         = max2(1, clog2w(DEPTH + 1))
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_in,
    input  logic signed [IN_W-1:0]  data_in,
    output logic                    push_out,
    output logic signed [OUT_W-1:0] data_out,
    output logic [FW-1:0]           fill
);

    localparam int PW  = max2(1, clog2w(DEPTH));
    localparam int ECW = max2(1, clog2w(EMIT_EVERY));

    logic signed [IN_W-1:0]  ring [DEPTH];
    logic [PW-1:0]           ptr;
    logic [ECW-1:0]          ecnt;
    logic signed [OUT_W-1:0] sum;
    logic signed [OUT_W-1:0] sum_next;

    // Entries start at zero, so the subtraction is exact while filling.
    assign sum_next = sum + OUT_W'(data_in) - OUT_W'(ring[ptr]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring[i] <= '0;
            end
            ptr      <= '0;
            ecnt     <= '0;
            sum      <= '0;
            fill     <= '0;
            push_out <= 1'b0;
            data_out <= '0;
        end else begin
            push_out <= 1'b0;
            if (push_in) begin
                ring[ptr] <= data_in;
                sum       <= sum_next;
                ptr       <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
                if (fill != FW'(DEPTH)) begin
                    fill <= fill + FW'(1);
                end
                if (EMIT_EN) begin
                    if (ecnt == ECW'(EMIT_EVERY - 1)) begin
                        ecnt     <= '0;
                        push_out <= 1'b1;
                        data_out <= sum_next;
                    end else begin
                        ecnt <= ecnt + ECW'(1);
                    end
                end else begin
                    push_out <= 1'b1;
                    data_out <= sum_next;
                end
            end
        end
    end

endmodule

// File: rtl/baseline_multiscale.sv
// Multi-timescale baseline: bins samples, cascades three window levels.
// Optional BASELINE_MULTISCALE_PARTIAL_EN adds pulses while L3 fills.
module baseline_multiscale
    import baseline_pkg::*;
#(
    parameter int DIN_W        = 25,
    parameter int SAMP_PER_BIN = SAMP_PER_BIN_DEF,
    parameter int D1           = D1_DEF,
    parameter int D2           = D2_DEF,
    parameter int D3           = D3_DEF,
    parameter int OUT_SHIFT    = 8,
    parameter int DOUT_W       = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DIN_W-1:0]  din,
    input  logic                     din_valid,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     dout_valid
`ifdef BASELINE_MULTISCALE_PARTIAL_EN
    ,
    output logic                     dout_partial
`endif
);

    localparam int W0  = DIN_W + clog2w(SAMP_PER_BIN);
    localparam int W1  = W0 + clog2w(D1);
    localparam int W2  = W1 + clog2w(D2);
    localparam int W3  = W2 + clog2w(D3);
    localparam int CW  = max2(1, clog2w(SAMP_PER_BIN));
    localparam int FW1 = max2(1, clog2w(D1 + 1));
    localparam int FW2 = max2(1, clog2w(D2 + 1));
    localparam int FW3 = max2(1, clog2w(D3 + 1));
    localparam int XW  = max2(W3, DOUT_W);

    if (DOUT_W < W3 - OUT_SHIFT) begin : g_width_check
        $error("baseline_multiscale: DOUT_W too small for W3-OUT_SHIFT");
    end

    logic [CW-1:0]        cnt;
    logic signed [W0-1:0] acc;
    logic signed [W0-1:0] acc_next;
    logic signed [W0-1:0] bin_sum;
    logic                 push0;

    assign acc_next = acc + W0'(din);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            bin_sum <= '0;
            push0   <= 1'b0;
        end else begin
            push0 <= 1'b0;
            if (din_valid) begin
                if (cnt == CW'(SAMP_PER_BIN - 1)) begin
                    cnt     <= '0;
                    acc     <= '0;
                    bin_sum <= acc_next;
                    push0   <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                    acc <= acc_next;
                end
            end
        end
    end

    logic                 l1_push;
    logic signed [W1-1:0] l1_data;
    logic [FW1-1:0]       l1_fill_unused;
    logic                 l2_push;
    logic signed [W2-1:0] l2_data;
    logic [FW2-1:0]       l2_fill_unused;
    logic                 l3_push;
    logic signed [W3-1:0] l3_data;
    logic [FW3-1:0]       l3_fill;

    window_level #(
        .IN_W      (W0),
        .DEPTH     (D1),
        .EMIT_EVERY(D1),
        .EMIT_EN   (1'b1)
    ) u_l1 (
        .clk     (clk),
        .rst     (rst),
        .push_in (push0),
        .data_in (bin_sum),
        .push_out(l1_push),
        .data_out(l1_data),
        .fill    (l1_fill_unused)
    );

    window_level #(
        .IN_W      (W1),
        .DEPTH     (D2),
        .EMIT_EVERY(D2),
        .EMIT_EN   (1'b1)
    ) u_l2 (
        .clk     (clk),
        .rst     (rst),
        .push_in (l1_push),
        .data_in (l1_data),
        .push_out(l2_push),
        .data_out(l2_data),
        .fill    (l2_fill_unused)
    );

    // L3 never decimates; push_out marks every window update.
    window_level #(
        .IN_W      (W2),
        .DEPTH     (D3),
        .EMIT_EVERY(1),
        .EMIT_EN   (1'b0)
    ) u_l3 (
        .clk     (clk),
        .rst     (rst),
        .push_in (l2_push),
        .data_in (l2_data),
        .push_out(l3_push),
        .data_out(l3_data),
        .fill    (l3_fill)
    );

    logic                 l3_full;
    logic signed [XW-1:0] l3_shr;

    assign l3_full = (l3_fill == FW3'(D3));
    assign l3_shr  = XW'(l3_data) >>> OUT_SHIFT;

`ifdef BASELINE_MULTISCALE_PARTIAL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dout         <= '0;
            dout_valid   <= 1'b0;
            dout_partial <= 1'b0;
        end else begin
            dout_valid   <= 1'b0;
            dout_partial <= 1'b0;
            if (l3_push) begin
                dout         <= DOUT_W'(l3_shr);
                dout_valid   <= 1'b1;
                dout_partial <= ~l3_full;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (l3_push && l3_full) begin
                dout       <= DOUT_W'(l3_shr);
                dout_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_baseline_multiscale.sv
// Directed bench for baseline_multiscale (SAMP_PER_BIN=4, D1=D2=D3=2).
// Covers BASELINE_MULTISCALE_PARTIAL_EN when that macro is defined.
module tb_baseline_multiscale;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     din_valid;
    logic signed [24:0]       din;
    logic signed [33:0]       dout0;
    logic signed [33:0]       dout1;
    logic                     dv0;
    logic                     dv1;
    logic                     p0;
    logic                     p1;

    always #5 clk = ~clk;

    baseline_multiscale #(
        .DIN_W(25), .SAMP_PER_BIN(4), .D1(2), .D2(2), .D3(2),
        .OUT_SHIFT(0), .DOUT_W(34)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout0),
        .dout_valid(dv0)
`ifdef BASELINE_MULTISCALE_PARTIAL_EN
        ,
        .dout_partial(p0)
`endif
    );

    baseline_multiscale #(
        .DIN_W(25), .SAMP_PER_BIN(4), .D1(2), .D2(2), .D3(2),
        .OUT_SHIFT(2), .DOUT_W(34)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout1),
        .dout_valid(dv1)
`ifdef BASELINE_MULTISCALE_PARTIAL_EN
        ,
        .dout_partial(p1)
`endif
    );

`ifndef BASELINE_MULTISCALE_PARTIAL_EN
    assign p0 = 1'b0;
    assign p1 = 1'b0;
`endif

    int     checks = 0;
    int     failures = 0;
    int     tick_n;
    int     full_n;
    int     part_n;
    int     first_tick;
    int     part_tick;
    longint first_dout;
    longint last_dout;
    longint last_dout1;
    longint part_dout;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        tick_n     = 0;
        full_n     = 0;
        part_n     = 0;
        first_tick = -1;
        part_tick  = -1;
        first_dout = 0;
        last_dout  = 0;
        last_dout1 = 0;
        part_dout  = 0;
    endtask

    // One clock: observe outputs at the falling edge, then drive inputs.
    task automatic tick(input logic r, input logic v, input logic signed [24:0] d);
        @(negedge clk);
        tick_n++;
        if (dv0) begin
            if (!p0) begin
                full_n++;
                if (full_n == 1) begin
                    first_tick = tick_n;
                    first_dout = dout0;
                end
                last_dout = dout0;
            end else begin
                part_n++;
                part_tick = tick_n;
                part_dout = dout0;
            end
        end
        if (dv1 && !p1) last_dout1 = dout1;
        rst       = r;
        din_valid = v;
        din       = d;
    endtask

    task automatic feed(input int n, input longint base, input int inc, input bit gap);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b1, 25'(base + longint'(i) * inc));
            if (gap) tick(1'b0, 1'b0, '0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        clear_stats();

        do_reset();
        check("reset_dout_valid", longint'(dv0), 0);
        check("reset_dout", dout0, 0);
        check("reset_dout_shift", dout1, 0);

        // Constant ones, continuous.
        clear_stats();
        feed(48, 1, 0, 1'b0);
        idle(5);
        check("ones_first_tick", first_tick, 37);
        check("ones_first_dout", first_dout, 32);
        check("ones_pulses", full_n, 2);
        check("ones_last_dout", last_dout, 32);
        check("ones_shift2_dout", last_dout1, 8);
`ifdef BASELINE_MULTISCALE_PARTIAL_EN
        check("partial_pulses", part_n, 1);
        check("partial_tick", part_tick, 21);
        check("partial_dout", part_dout, 16);
`endif
        idle(2);
        check("ones_hold_valid", longint'(dv0), 0);
        check("ones_hold_dout", dout0, 32);

        // Negative input, sign through the shift.
        do_reset();
        clear_stats();
        feed(32, -1, 0, 1'b0);
        idle(5);
        check("neg_first_tick", first_tick, 37);
        check("neg_dout", first_dout, -32);
        check("neg_shift2_dout", last_dout1, -8);

        // Alternating valid.
        do_reset();
        clear_stats();
        feed(48, 1, 0, 1'b1);
        idle(5);
        check("gap_first_tick", first_tick, 68);
        check("gap_first_dout", first_dout, 32);
        check("gap_pulses", full_n, 2);
        check("gap_last_dout", last_dout, 32);

        // Ramp din = n.
        do_reset();
        clear_stats();
        feed(48, 0, 1, 1'b0);
        idle(5);
        check("ramp_first_tick", first_tick, 37);
        check("ramp_first_dout", first_dout, 496);
        check("ramp_pulses", full_n, 2);
        check("ramp_second_dout", last_dout, 1008);

        // Mid-stream reset after 20 samples.
        clear_stats();
        feed(20, 1, 0, 1'b0);
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check("midrst_dout_valid", longint'(dv0), 0);
        check("midrst_dout", dout0, 0);
        check("midrst_dout_shift", dout1, 0);
        check("midrst_partial", longint'(p0), 0);
        clear_stats();
        feed(32, 1, 0, 1'b0);
        idle(5);
        check("midrst_first_tick", first_tick, 37);
        check("midrst_first_dout", first_dout, 32);
        check("midrst_pulses", full_n, 1);
`ifdef BASELINE_MULTISCALE_PARTIAL_EN
        check("midrst_partial_tick", part_tick, 21);
        check("midrst_partial_dout", part_dout, 16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
